// File: rtl/bcd_convert_sequencer.sv
// Shared sequential double-dabble binary-to-BCD converter with a two-way
// round-robin front end; one shift/add-3 iteration per clock.

module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bcd_convert_sequencer #(
  parameter int BIN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [BIN_W-1:0] bin0,
  input  logic             req1,
  input  logic [BIN_W-1:0] bin1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             valid,
  output logic             src,
  output logic [3:0]       ribuan,
  output logic [3:0]       ratusan,
  output logic [3:0]       puluhan,
  output logic [3:0]       satuan
);
  localparam int NUM_DIG = 4;
  localparam int ACC_W   = 4 * NUM_DIG;
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                          state, state_nxt;
  logic [BIN_W-1:0]                opnd, opnd_nxt;
  logic [ACC_W-1:0]                acc, acc_nxt;
  logic [CNT_W-1:0]                cnt, cnt_nxt;
  logic                            ptr, ptr_nxt;
  logic                            gnt, gnt_nxt;
  logic                            ack0_q, ack0_nxt, ack1_q, ack1_nxt;
  logic                            busy_q, busy_nxt, valid_q, valid_nxt;
  logic                            src_q, src_nxt;
  logic [NUM_DIG-1:0][3:0]         dig, dig_nxt;

  // add-3 correction applied to every digit before the shift
  logic [NUM_DIG-1:0][3:0]         adj;
  genvar g;
  generate
    for (g = 0; g < NUM_DIG; g++) begin : g_dig
      bcd_digit_adj u_adj (.din(acc[4*g +: 4]), .dout(adj[g]));
    end
  endgenerate

  logic [ACC_W+BIN_W-1:0] sh;
  logic [ACC_W-1:0]       acc_sh;
  logic [BIN_W-1:0]       opnd_sh;
  assign sh      = {adj, opnd} << 1;
  assign acc_sh  = sh[ACC_W+BIN_W-1:BIN_W];
  assign opnd_sh = sh[BIN_W-1:0];

  // lone requester wins; the pointer only breaks ties
  logic gsel;
  assign gsel = req1 & (~req0 | ptr);

  always_comb begin
    state_nxt = state;
    opnd_nxt  = opnd;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    ack0_nxt  = 1'b0;
    ack1_nxt  = 1'b0;
    busy_nxt  = busy_q;
    valid_nxt = 1'b0;
    src_nxt   = src_q;
    dig_nxt   = dig;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          opnd_nxt  = gsel ? bin1 : bin0;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ack0_nxt  = ~gsel;
          ack1_nxt  = gsel;
          busy_nxt  = 1'b1;
          gnt_nxt   = gsel;
          ptr_nxt   = ~gsel;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        acc_nxt  = acc_sh;
        opnd_nxt = opnd_sh;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == LAST) begin
          dig_nxt   = acc_sh;
          src_nxt   = gnt;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      opnd    <= '0;
      acc     <= '0;
      cnt     <= '0;
      ptr     <= 1'b0;
      gnt     <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
      dig     <= '0;
    end else begin
      state   <= state_nxt;
      opnd    <= opnd_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      ack0_q  <= ack0_nxt;
      ack1_q  <= ack1_nxt;
      busy_q  <= busy_nxt;
      valid_q <= valid_nxt;
      src_q   <= src_nxt;
      dig     <= dig_nxt;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign busy    = busy_q;
  assign valid   = valid_q;
  assign src     = src_q;
  assign ribuan  = dig[3];
  assign ratusan = dig[2];
  assign puluhan = dig[1];
  assign satuan  = dig[0];

endmodule

// File: tb/tb_bcd_convert_sequencer.sv
// Directed bench for bcd_convert_sequencer: vector table of single conversions
// plus hand-written arbitration, back-to-back and reset-abort sequences.

module tb_bcd_convert_sequencer;
  logic        clk = 1'b0;
  logic        rst, req0, req1;
  logic [11:0] bin0, bin1;
  logic        ack0, ack1, busy, valid, src;
  logic [3:0]  ribuan, ratusan, puluhan, satuan;

  int checks = 0;
  int fails  = 0;

  bcd_convert_sequencer #(.BIN_W(12)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .bin0(bin0), .req1(req1), .bin1(bin1),
    .ack0(ack0), .ack1(ack1), .busy(busy), .valid(valid), .src(src),
    .ribuan(ribuan), .ratusan(ratusan), .puluhan(puluhan), .satuan(satuan)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          who;
    logic [11:0] bin;
    logic [15:0] exp;
  } vec_t;

  function automatic logic [15:0] digits();
    return {ribuan, ratusan, puluhan, satuan};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one isolated conversion: ack latency, busy length, valid latency, result
  task automatic run_conv(input bit who, input logic [11:0] b, input logic [15:0] exp_d);
    int n, nb;
    bit got;
    @(negedge clk);
    if (who) begin req1 = 1'b1; bin1 = b; end
    else     begin req0 = 1'b1; bin0 = b; end
    n = 0; got = 0;
    while (!got && n < 5) begin
      @(negedge clk); n++;
      got = who ? ack1 : ack0;
    end
    chk("ack_latency", n, 1);
    req0 = 1'b0; req1 = 1'b0;
    nb = busy; n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (valid) got = 1; else nb += busy;
    end
    chk("valid_latency", n, 12);
    chk("busy_cycles", nb, 12);
    chk("digits", digits(), exp_d);
    chk("src", src, who);
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!valid && n < lim);
  endtask

  vec_t vecs[12];

  initial begin
    int n, k, bad, ch;
    bit order[4];

    vecs[0]  = '{0, 12'd1234, 16'h1234};
    vecs[1]  = '{0, 12'd0,    16'h0000};
    vecs[2]  = '{0, 12'd4095, 16'h4095};
    vecs[3]  = '{1, 12'd999,  16'h0999};
    vecs[4]  = '{1, 12'd7,    16'h0007};
    vecs[5]  = '{0, 12'd1000, 16'h1000};
    vecs[6]  = '{1, 12'd9,    16'h0009};
    vecs[7]  = '{0, 12'd10,   16'h0010};
    vecs[8]  = '{1, 12'd255,  16'h0255};
    vecs[9]  = '{0, 12'd2048, 16'h2048};
    vecs[10] = '{1, 12'd100,  16'h0100};
    vecs[11] = '{1, 12'd4095, 16'h4095};

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ack0, ack1, busy, valid, src, digits()}, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_conv(vecs[i].who, vecs[i].bin, vecs[i].exp);

    // simultaneous requests after reset, back-to-back service
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req0 = 1'b1; bin0 = 12'd999; req1 = 1'b1; bin1 = 12'd7;
    @(negedge clk);
    chk("both_first_grant", {ack0, ack1}, 2'b10);
    req0 = 1'b0;
    wait_valid(20, n);
    chk("both_first_latency", n, 12);
    chk("both_first_src", src, 0);
    chk("both_first_digits", digits(), 16'h0999);
    @(negedge clk);
    chk("both_second_ack_no_gap", {ack0, ack1}, 2'b01);
    req1 = 1'b0;
    wait_valid(20, n);
    chk("both_second_latency", n, 12);
    chk("both_second_src", src, 1);
    chk("both_second_digits", digits(), 16'h0007);

    // continuous requests alternate
    @(negedge clk);
    req0 = 1'b1; bin0 = 12'd1000; req1 = 1'b1; bin1 = 12'd2000;
    k = 0; bad = 0;
    for (int c = 0; c < 80 && k < 4; c++) begin
      @(negedge clk);
      if (ack0 && ack1) bad++;
      if ((ack0 || ack1) && valid) bad++;
      if (ack0 || ack1) begin
        order[k] = ack1; k++;
        if (k == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    chk("rr_grant_count", k, 4);
    chk("rr_order", {order[0], order[1], order[2], order[3]}, 4'b0101);
    chk("rr_ack_overlap", bad, 0);
    wait_valid(20, n);
    chk("rr_last_result", {src, digits()}, {1'b1, 16'h2000});

    // reset during SHIFT cycle 5 aborts the job
    @(negedge clk);
    req0 = 1'b1; bin0 = 12'd1234;
    @(negedge clk);
    chk("abort_ack", ack0, 1);
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs_zero", {ack0, ack1, busy, valid, src, digits()}, 0);
    ch = 0;
    repeat (20) begin @(negedge clk); if (valid || ack0 || ack1) ch++; end
    chk("abort_no_valid", ch, 0);
    run_conv(1, 12'd42, 16'h0042);

    // operand changed after capture must not affect the result
    @(negedge clk);
    req0 = 1'b1; bin0 = 12'd1234;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack0 && n < 5);
    chk("capture_ack", ack0, 1);
    req0 = 1'b0; bin0 = 12'd3333;
    @(negedge clk); bin0 = 12'd4095;
    wait_valid(20, n);
    chk("capture_latency", n, 11);
    chk("capture_digits", digits(), 16'h1234);
    ch = 0;
    repeat (20) begin
      @(negedge clk);
      bin0 = 12'($urandom_range(0, 4095));
      bin1 = 12'($urandom_range(0, 4095));
      if (digits() !== 16'h1234 || src !== 1'b0 || valid || busy) ch++;
    end
    chk("hold_20_idle", ch, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
